// File: rtl/fetch_unit.sv
// Instruction fetch FSM: requests one word per PC, captures it into IR and strobes pc_en.
// Define FETCH_TIMEOUT_EN to add a 4-bit REQ watchdog that raises a sticky fetch_error.
module fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] PCNext,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [3:0]  Id,
  output logic [17:0] Imm,
  output logic        instr_valid,
  output logic        pc_en,
  output logic        halted,
  output logic        fetch_error
);

  typedef enum logic [1:0] {StIdle, StReq, StValid, StHalt} state_e;

  localparam logic [3:0] OpEnd = 4'b0010;

  state_e      state;
  logic [31:0] ir;
  logic        timeout;

  assign Id  = ir[31:28];
  assign Imm = ir[17:0];

  // Middle IR bits and the byte offset of the PC are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{ir[27:18], PCNext[1:0]};

`ifdef FETCH_TIMEOUT_EN
  logic [3:0] wd;

  // Fires on the 15th consecutive REQ cycle without a memory response.
  assign timeout = (state == StReq) && !imem_ready && (wd == 4'd14);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd          <= 4'd0;
      fetch_error <= 1'b0;
    end else if (state == StReq) begin
      if (!imem_ready) wd <= wd + 4'd1;
      if (timeout) fetch_error <= 1'b1;
    end else begin
      wd <= 4'd0;
    end
  end
`else
  assign timeout     = 1'b0;
  assign fetch_error = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= StIdle;
      ir          <= 32'd0;
      imem_req    <= 1'b0;
      imem_addr   <= 32'd0;
      instr_valid <= 1'b0;
      pc_en       <= 1'b0;
      halted      <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      pc_en       <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            state     <= StReq;
            imem_req  <= 1'b1;
            imem_addr <= {PCNext[31:2], 2'b00};
          end
        end
        StReq: begin
          if (imem_ready) begin
            ir          <= imem_rdata;
            state       <= StValid;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            pc_en       <= 1'b1;
          end else if (timeout) begin
            state    <= StHalt;
            imem_req <= 1'b0;
            halted   <= 1'b1;
          end
        end
        StValid: begin
          if (ir[31:28] == OpEnd) begin
            state  <= StHalt;
            halted <= 1'b1;
          end else if (start) begin
            state     <= StReq;
            imem_req  <= 1'b1;
            imem_addr <= {PCNext[31:2], 2'b00};
          end else begin
            state <= StIdle;
          end
        end
        StHalt: begin
          state <= StHalt;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 start  input  1  level; enables fetching while high.
REQ-004 PCNext  input  32  current program counter from PC register.
REQ-005 imem_ready  input  1  memory response strobe; imem_rdata valid when high.
REQ-006 imem_rdata  input  32  fetched instruction word.
REQ-007 imem_req  output  1  memory request, held high until imem_ready.
REQ-008 imem_addr  output  32  word address {PCNext[31:2],2'b00}, latched at request start.
REQ-009 Id  output  4  opcode = IR[31:28].
REQ-010 Imm  output  18  immediate = IR[17:0].
REQ-011 instr_valid  output  1  one-cycle pulse; IR holds a newly fetched instruction.
REQ-012 pc_en  output  1  PC-advance strobe; equals instr_valid.
REQ-013 halted  output  1  high in HALT state.
REQ-014 fetch_error  output  1  sticky watchdog error (0 when FETCH_TIMEOUT_EN undefined).

Function
REQ-015 The FSM SHALL have states IDLE, REQ, VALID, HALT.
REQ-016 IDLE: imem_req=0; start=1 -> REQ next cycle, latching imem_addr from PCNext.
REQ-017 REQ: imem_req=1, imem_addr stable; imem_ready=1 -> IR<=imem_rdata, -> VALID.
REQ-018 Request-to-valid latency SHALL be exactly one cycle after the imem_ready cycle; zero-wait memory yields one instruction every 2 cycles.
REQ-019 VALID: instr_valid=1, pc_en=1 for exactly one cycle; IR[31:28]=4'b0010 (END) -> HALT; else start=1 -> REQ (re-latch PCNext); else -> IDLE.
REQ-020 Id/Imm SHALL reflect IR in all states; IR SHALL change only on REQ-state capture.
REQ-021 HALT: imem_req=0, instr_valid=0, halted=1; exit only by reset.
REQ-022 start deasserted during REQ SHALL NOT abort the outstanding request; fetch completes, then IDLE.
REQ-023 imem_ready outside REQ SHALL be ignored.
REQ-024 imem_addr SHALL wrap modulo 2^32; PCNext[1:0] ignored.

Reset
REQ-025 Reset SHALL force IDLE, IR=0 (Id=4'b0000 NOP, Imm=0), imem_req=0, imem_addr=0, instr_valid=0, pc_en=0, halted=0, fetch_error=0, watchdog=0.
REQ-026 Reset mid-REQ SHALL drop imem_req asynchronously; a late imem_ready after release SHALL be ignored unless a new REQ is active.

Configuration
REQ-027 Macro FETCH_TIMEOUT_EN defined: 4-bit watchdog counts cycles in REQ with imem_ready=0, clears on entering REQ; reaching 15 with imem_ready=0 sets fetch_error sticky and moves to HALT with IR unchanged.
REQ-028 FETCH_TIMEOUT_EN undefined: no counter; REQ waits indefinitely; fetch_error tied 0.

Verification
REQ-029 Reset, start=1, PCNext=0x0000_0010, imem_ready=1 next cycle, rdata=0xC000_0040 -> imem_addr=0x10; instr_valid one cycle; Id=4'hC, Imm=18'h00040.
REQ-030 PCNext=0x0000_0007, imem_ready after 3 wait cycles -> imem_addr=0x0000_0004 stable, imem_req high 4 cycles, single instr_valid.
REQ-031 rdata=0x2000_0000 -> Id=4'h2, VALID then HALT; halted=1, imem_req stays 0 despite start=1.
REQ-032 start dropped in REQ cycle 2, ready in cycle 3 -> instruction delivered, then IDLE, imem_req=0.
REQ-033 Reset asserted mid-REQ -> imem_req=0 same cycle, Id=0, Imm=0; imem_ready pulse after release ignored.
REQ-034 FETCH_TIMEOUT_EN defined, imem_ready held 0 -> fetch_error=1 after 15 wait cycles, halted=1; undefined -> imem_req stays high, fetch_error=0.
